fetch_stage: RTL and testbench

- Instruction fetch stage; sits directly upstream of decode_top.
- Serves decode's instruction requests on the f2d channel from a synchronous instruction memory.
- Takes branch/jump redirects from decode on the d2f channel.
- Passive on both channels: decode drives each *_R, fetch drives each *_A. All channels use 4-phase return-to-zero handshakes.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/hs_sync.sv | 25 ++
 rtl/fetch_stage.sv | 142 ++++++++++++++
 tb/tb_fetch_stage.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the fetch/decode pipeline.
//   F2D_W / D2F_W        : channel widths of fetch->decode and decode->fetch
//   F2D_INSTR_HI/LO      : instruction field inside the f2d word
//   D2F_REDIR_BIT        : redirect-enable bit inside the d2f word
//   fetch_state_t        : state encoding of the fetch FSM
package mips_pkg;

    localparam int F2D_W         = 64;
    localparam int D2F_W         = 33;
    localparam int F2D_INSTR_HI  = 63;
    localparam int F2D_INSTR_LO  = 32;
    localparam int D2F_REDIR_BIT = 32;

    typedef enum logic [2:0] {
        FS_IDLE  = 3'd0,
        FS_READ  = 3'd1,
        FS_CAPT  = 3'd2,
        FS_RESP  = 3'd3,
        FS_REDIR = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/hs_sync.sv
// Two-flop synchroniser for a single handshake request line.
//   clk : destination clock
//   rst : asynchronous, active-high reset (clears both flops to 0)
//   d   : asynchronous input
//   q   : synchronised output, two clk cycles behind d
module hs_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] sync_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], d};
        end
    end

    assign q = sync_reg[1];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage, directly upstream of decode.
// Serves decode's instruction requests (f2d channel) from a synchronous
// instruction memory and accepts branch/jump redirects (d2f channel).
// Fetch is passive on both channels: decode drives *_R, fetch drives *_A,
// both using 4-phase return-to-zero handshakes.
//
// Ports:
//   clk        : clock, all state on the rising edge
//   Z_R        : asynchronous active-high reset
//   f2d_top_R  : decode requests the next instruction
//   f2d_top_A  : fetch acknowledge; f2d_top valid while high
//   f2d_top    : {instr[31:0], zeros, next_pc[ADDR_W-1:0]}
//   d2f_R      : decode presents a redirect
//   d2f        : {redirect_en, target[31:0]}
//   d2f_A      : fetch acknowledges the redirect
//   imem_rd    : instruction memory read strobe
//   imem_addr  : word address pc[ADDR_W-1:2]
//   imem_data  : read data, valid the cycle after imem_rd
//
// Build option: define FETCH_SYNC_EN to pass both request lines through a
// 2-flop synchroniser (adds 2 cycles to every request-edge reaction and
// allows the requests to be asynchronous to clk).
module fetch_stage
    import mips_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              Z_R,
    input  logic              f2d_top_R,
    output logic              f2d_top_A,
    output logic [F2D_W-1:0]  f2d_top,
    input  logic              d2f_R,
    input  logic [D2F_W-1:0]  d2f,
    output logic              d2f_A,
    output logic              imem_rd,
    output logic [ADDR_W-3:0] imem_addr,
    input  logic [31:0]       imem_data
);

    fetch_state_t      state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pc_inc;
    logic [F2D_W-1:0]  f2d_next;
    logic [1:0]        req_raw;
    logic [1:0]        req_fsm;
    logic              f2d_req;
    logic              d2f_req;
    logic              unused_d2f;

    // Request lines packed as {d2f, f2d} so both paths share one structure.
    assign req_raw = {d2f_R, f2d_top_R};

`ifdef FETCH_SYNC_EN
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req_sync
            hs_sync u_sync (
                .clk (clk),
                .rst (Z_R),
                .d   (req_raw[gi]),
                .q   (req_fsm[gi])
            );
        end
    endgenerate
`else
    assign req_fsm = req_raw;
`endif

    assign f2d_req = req_fsm[0];
    assign d2f_req = req_fsm[1];

    // Only target bits [ADDR_W-1:2] reach the pc; the rest are ignored.
    assign unused_d2f = ^d2f[31:0];

    // Wraps modulo 2^ADDR_W by construction of the width.
    assign pc_inc = pc_reg + {{(ADDR_W-3){1'b0}}, 3'b100};

    // Response word: instruction on top, zero-extended next pc below.
    always_comb begin
        f2d_next = '0;
        f2d_next[F2D_INSTR_HI:F2D_INSTR_LO] = imem_data;
        f2d_next[ADDR_W-1:0]                = pc_inc;
    end

    always_ff @(posedge clk or posedge Z_R) begin
        if (Z_R) begin
            state_reg <= FS_IDLE;
            pc_reg    <= RESET_PC[ADDR_W-1:0];
            f2d_top_A <= 1'b0;
            d2f_A     <= 1'b0;
            f2d_top   <= '0;
            imem_rd   <= 1'b0;
            imem_addr <= RESET_PC[ADDR_W-1:2];
        end else begin
            case (state_reg)
                FS_IDLE: begin
                    // Redirect wins a tie so the next fetch uses the target.
                    if (d2f_req) begin
                        d2f_A     <= 1'b1;
                        state_reg <= FS_REDIR;
                        if (d2f[D2F_REDIR_BIT]) begin
                            pc_reg <= {d2f[ADDR_W-1:2], 2'b00};
                        end
                    end else if (f2d_req) begin
                        imem_rd   <= 1'b1;
                        imem_addr <= pc_reg[ADDR_W-1:2];
                        state_reg <= FS_READ;
                    end
                end
                FS_READ: begin
                    imem_rd   <= 1'b0;
                    state_reg <= FS_CAPT;
                end
                FS_CAPT: begin
                    // Data is registered a full cycle before A rises.
                    f2d_top   <= f2d_next;
                    state_reg <= FS_RESP;
                end
                FS_RESP: begin
                    if (!f2d_top_A) begin
                        f2d_top_A <= 1'b1;
                    end else if (!f2d_req) begin
                        f2d_top_A <= 1'b0;
                        pc_reg    <= pc_inc;
                        state_reg <= FS_IDLE;
                    end
                end
                FS_REDIR: begin
                    if (!d2f_req) begin
                        d2f_A     <= 1'b0;
                        state_reg <= FS_IDLE;
                    end
                end
                default: begin
                    state_reg <= FS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: sequential fetch, redirects (enabled
// and disabled), simultaneous requests, redirect during a fetch, pc wrap and
// reset in the middle of a response. Memory word i holds 0x20010001 + i.
module tb_fetch_stage;

`ifdef FETCH_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        Z_R;
    logic        f2d_top_R;
    logic        f2d_top_A;
    logic [63:0] f2d_top;
    logic        d2f_R;
    logic [32:0] d2f;
    logic        d2f_A;
    logic        imem_rd;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;

    logic [31:0] mem [256];

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    // Synchronous instruction memory: data valid the cycle after imem_rd.
    always @(posedge clk) begin
        if (imem_rd) imem_data <= mem[imem_addr];
    end

    fetch_stage #(.ADDR_W(10), .RESET_PC(32'h0)) dut (
        .clk       (clk),
        .Z_R       (Z_R),
        .f2d_top_R (f2d_top_R),
        .f2d_top_A (f2d_top_A),
        .f2d_top   (f2d_top),
        .d2f_R     (d2f_R),
        .d2f       (d2f),
        .d2f_A     (d2f_A),
        .imem_rd   (imem_rd),
        .imem_addr (imem_addr),
        .imem_data (imem_data)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_f2d_a(input string tag, input logic lvl);
        int cyc = 0;
        while (f2d_top_A !== lvl && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, {63'd0, f2d_top_A}, {63'd0, lvl});
    endtask

    task automatic wait_d2f_a(input string tag, input logic lvl);
        int cyc = 0;
        while (d2f_A !== lvl && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, {63'd0, d2f_A}, {63'd0, lvl});
    endtask

    task automatic fetch(input string tag, input logic [31:0] instr, input logic [31:0] npc);
        @(negedge clk);
        f2d_top_R = 1'b1;
        wait_f2d_a({tag, "_ack"}, 1'b1);
        check({tag, "_data"}, f2d_top, {instr, npc});
        $display("fetch %s: f2d_top=%h", tag, f2d_top);
        f2d_top_R = 1'b0;
        wait_f2d_a({tag, "_release"}, 1'b0);
        check({tag, "_hold"}, f2d_top, {instr, npc});
    endtask

    task automatic redirect(input string tag, input logic en, input logic [31:0] target);
        @(negedge clk);
        d2f   = {en, target};
        d2f_R = 1'b1;
        wait_d2f_a({tag, "_ack"}, 1'b1);
        $display("redirect %s: en=%0b target=%h", tag, en, target);
        d2f_R = 1'b0;
        wait_d2f_a({tag, "_release"}, 1'b0);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 256; i++) mem[i] = 32'h2001_0001 + i;
        imem_data = '0;
        f2d_top_R = 1'b0;
        d2f_R     = 1'b0;
        d2f       = '0;
        Z_R       = 1'b1;

        // Reset state
        #1;
        check("rst_f2d_a", {63'd0, f2d_top_A}, 64'd0);
        check("rst_d2f_a", {63'd0, d2f_A}, 64'd0);
        check("rst_f2d_top", f2d_top, 64'd0);
        check("rst_imem_rd", {63'd0, imem_rd}, 64'd0);
        check("rst_imem_addr", {56'd0, imem_addr}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        Z_R = 1'b0;

        // First fetch with latency check: data at E+2, A after E+3
        @(negedge clk);
        f2d_top_R = 1'b1;
        repeat (3 + SYNC_LAT) @(negedge clk);
        check("lat_a_low", {63'd0, f2d_top_A}, 64'd0);
        check("lat_data_early", f2d_top, {32'h2001_0001, 32'd4});
        @(negedge clk);
        check("lat_a_high", {63'd0, f2d_top_A}, 64'd1);
        $display("fetch seq0: f2d_top=%h", f2d_top);
        f2d_top_R = 1'b0;
        wait_f2d_a("seq0_release", 1'b0);

        fetch("seq1", 32'h2001_0002, 32'd8);
        fetch("seq2", 32'h2001_0003, 32'd12);
        fetch("seq3", 32'h2001_0004, 32'd16);

        // Enabled redirect, then a disabled one that leaves pc alone
        redirect("redir100", 1'b1, 32'h0000_0100);
        fetch("after_redir", 32'h2001_0041, 32'h104);
        redirect("redir_off", 1'b0, 32'h0000_0200);
        fetch("after_noredir", 32'h2001_0042, 32'h108);

        // Both requests together: redirect acknowledged first
        @(negedge clk);
        d2f       = {1'b1, 32'h0000_0040};
        d2f_R     = 1'b1;
        f2d_top_R = 1'b1;
        cyc = 0;
        while (!(d2f_A || f2d_top_A) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("simul_d2f_first", {63'd0, d2f_A}, 64'd1);
        check("simul_f2d_wait", {63'd0, f2d_top_A}, 64'd0);
        d2f_R = 1'b0;
        wait_d2f_a("simul_d2f_release", 1'b0);
        wait_f2d_a("simul_f2d_ack", 1'b1);
        check("simul_data", f2d_top, {32'h2001_0011, 32'h44});
        $display("fetch simul: f2d_top=%h", f2d_top);
        f2d_top_R = 1'b0;
        wait_f2d_a("simul_f2d_release", 1'b0);

        // Redirect raised while the fetch is in READ: delay-slot order
        @(negedge clk);
        f2d_top_R = 1'b1;
        repeat (1 + SYNC_LAT) @(negedge clk);
        d2f   = {1'b1, 32'h0000_0080};
        d2f_R = 1'b1;
        wait_f2d_a("slot_ack", 1'b1);
        check("slot_data", f2d_top, {32'h2001_0012, 32'h48});
        check("slot_no_d2f_a", {63'd0, d2f_A}, 64'd0);
        $display("fetch slot: f2d_top=%h", f2d_top);
        f2d_top_R = 1'b0;
        wait_f2d_a("slot_release", 1'b0);
        wait_d2f_a("slot_redir_ack", 1'b1);
        d2f_R = 1'b0;
        wait_d2f_a("slot_redir_release", 1'b0);
        fetch("slot_target", 32'h2001_0021, 32'h84);

        // Wrap: target 0x7FE masks to pc 0x3FC
        redirect("redir_wrap", 1'b1, 32'h0000_07FE);
        fetch("wrap_last", 32'h2001_0100, 32'h0);
        fetch("wrap_first", 32'h2001_0001, 32'h4);

        // Reset during RESP drops A immediately
        @(negedge clk);
        f2d_top_R = 1'b1;
        wait_f2d_a("rstmid_ack", 1'b1);
        #2;
        Z_R = 1'b1;
        #1;
        check("rstmid_a", {63'd0, f2d_top_A}, 64'd0);
        check("rstmid_f2d_top", f2d_top, 64'd0);
        check("rstmid_imem_addr", {56'd0, imem_addr}, 64'd0);
        $display("reset mid-RESP: f2d_top_A=%0b", f2d_top_A);
        f2d_top_R = 1'b0;
        @(negedge clk);
        Z_R = 1'b0;
        fetch("post_reset", 32'h2001_0001, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
